// File: rtl/gcd_arb_pkg.sv
// Shared types and widths for the multi-client GCD arbiter.
// The GCD request is {a, b}, with 16 bits each, and the GCD result is 16 bits.
package gcd_arb_pkg;

   localparam int GCD_REQ_NBITS  = 32;
   localparam int GCD_RESP_NBITS = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/gcd_rr_arb.sv
// Combinational round-robin scan: returns the first valid requester
// at or after ptr, wrapping modulo NREQ.
module gcd_rr_arb
   import gcd_arb_pkg::*;
#(
   parameter  int NREQ          = 4,
   localparam int c_owner_nbits = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]          val,
   input  logic [c_owner_nbits-1:0] ptr,
   output logic [c_owner_nbits-1:0] grant,
   output logic                     any_val
);

   int idx;

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      grant   = '0;
      any_val = 1'b0;
      idx     = 0;
      for (int off = 0; off < NREQ; off++) begin
         idx = (int'(ptr) + off) % NREQ;
         if (!any_val && val[idx]) begin
            grant   = c_owner_nbits'(idx);
            any_val = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gcd_unit_arbiter.sv
// Shares one GCD unit between NREQ val/rdy requesters. Requesters are chosen round-robin,
// and the result of the single in-flight transaction goes back to the requester that owns it.
module gcd_unit_arbiter
   import gcd_arb_pkg::*;
#(
   parameter  int NREQ          = 4,
   localparam int c_owner_nbits = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NREQ-1:0]                 req_val,
   output logic [NREQ-1:0]                 req_rdy,
   input  logic [GCD_REQ_NBITS*NREQ-1:0]   req_msg,
   output logic [NREQ-1:0]                 resp_val,
   input  logic [NREQ-1:0]                 resp_rdy,
   output logic [GCD_RESP_NBITS-1:0]       resp_msg,
   output logic                            gcd_istream_val,
   input  logic                            gcd_istream_rdy,
   output logic [GCD_REQ_NBITS-1:0]        gcd_istream_msg,
   input  logic                            gcd_ostream_val,
   output logic                            gcd_ostream_rdy,
   input  logic [GCD_RESP_NBITS-1:0]       gcd_ostream_msg,
   output logic                            busy,
   output logic [c_owner_nbits-1:0]        owner
);

   state_t                   state;
   logic [c_owner_nbits-1:0] prio_ptr;
   logic [c_owner_nbits-1:0] grant;
   logic [c_owner_nbits-1:0] next_ptr;
   logic                     any_val;
   logic                     istream_fire;
   logic                     ostream_fire;

   gcd_rr_arb #(.NREQ(NREQ)) u_rr_arb (
      .val     (req_val),
      .ptr     (prio_ptr),
      .grant   (grant),
      .any_val (any_val)
   );

   assign next_ptr     = (grant == c_owner_nbits'(NREQ - 1)) ? '0 : grant + 1'b1;
   assign istream_fire = gcd_istream_val && gcd_istream_rdy;
   assign ostream_fire = gcd_ostream_val && gcd_ostream_rdy;

   always_comb begin
      gcd_istream_msg = req_msg[GCD_REQ_NBITS-1:0];
      for (int i = 1; i < NREQ; i++) begin
         if (grant == c_owner_nbits'(i))
            gcd_istream_msg = req_msg[i*GCD_REQ_NBITS +: GCD_REQ_NBITS];
      end
   end

   always_comb begin
      req_rdy         = '0;
      resp_val        = '0;
      gcd_istream_val = 1'b0;
      gcd_ostream_rdy = 1'b0;
      resp_msg        = gcd_ostream_msg;
      busy            = 1'b0;
      case (state)
         IDLE: begin
            gcd_istream_val = any_val;
            if (any_val)
               req_rdy[grant] = gcd_istream_rdy;
         end
         BUSY: begin
            busy            = 1'b1;
            resp_val[owner] = gcd_ostream_val;
            gcd_ostream_rdy = resp_rdy[owner];
         end
         default: begin
            req_rdy         = 'x;
            resp_val        = 'x;
            gcd_istream_val = 1'bx;
            gcd_ostream_rdy = 1'bx;
            resp_msg        = 'x;
            busy            = 1'bx;
         end
      endcase
   end

   // The GCD unit is reset in the same cycle as this block, so clearing the state also discards any in-flight result.
   // NOTE: sequential state uses non-blocking assignments only, so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         prio_ptr <= '0;
         owner    <= '0;
      end else begin
         case (state)
            IDLE: if (istream_fire) begin
               owner    <= grant;
               prio_ptr <= next_ptr;
               state    <= BUSY;
            end
            BUSY: if (ostream_fire)
               state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_unit_arbiter.sv
// Directed bench for gcd_unit_arbiter with a behavioural GCD unit that has a fixed compute latency.
module tb_gcd_unit_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_val, req_rdy, resp_val, resp_rdy;
   logic [127:0] req_msg;
   logic [15:0]  resp_msg;
   logic         gcd_istream_val, gcd_istream_rdy, gcd_ostream_val, gcd_ostream_rdy;
   logic [31:0]  gcd_istream_msg;
   logic [15:0]  gcd_ostream_msg;
   logic         busy;
   logic [1:0]   owner;

   int checks   = 0;
   int failures = 0;

   logic [3:0] hold_mask;
   logic       gcd_hold;
   int         grant_log[$];
   int         resp_idx_log[$];
   int         resp_msg_log[$];

   always #5 clk = ~clk;

   gcd_unit_arbiter #(.NREQ(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_val         (req_val),
      .req_rdy         (req_rdy),
      .req_msg         (req_msg),
      .resp_val        (resp_val),
      .resp_rdy        (resp_rdy),
      .resp_msg        (resp_msg),
      .gcd_istream_val (gcd_istream_val),
      .gcd_istream_rdy (gcd_istream_rdy),
      .gcd_istream_msg (gcd_istream_msg),
      .gcd_ostream_val (gcd_ostream_val),
      .gcd_ostream_rdy (gcd_ostream_rdy),
      .gcd_ostream_msg (gcd_ostream_msg),
      .busy            (busy),
      .owner           (owner)
   );

   // Behavioural GCD unit: accepts a request, computes for a few cycles, then holds its result until it is taken.
   logic [1:0]  g_st;
   logic [15:0] g_a, g_b, g_res;
   int          g_cnt;

   function automatic logic [15:0] gcd_fn(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   assign gcd_istream_rdy = (g_st == 2'd0) && !gcd_hold;
   assign gcd_ostream_val = (g_st == 2'd2);
   assign gcd_ostream_msg = g_res;

   always @(posedge clk) begin
      if (!reset) begin
         g_st  <= 2'd0;
         g_res <= '0;
      end else begin
         case (g_st)
            2'd0: if (gcd_istream_val && gcd_istream_rdy) begin
               g_a   <= gcd_istream_msg[31:16];
               g_b   <= gcd_istream_msg[15:0];
               g_cnt <= 3;
               g_st  <= 2'd1;
            end
            2'd1: if (g_cnt == 0) begin
               g_res <= gcd_fn(g_a, g_b);
               g_st  <= 2'd2;
            end else g_cnt <= g_cnt - 1;
            default: if (gcd_ostream_rdy) g_st <= 2'd0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int idx;
      idx = -1;
      if ($countones(v) == 1)
         for (int i = 0; i < 4; i++) if (v[i]) idx = i;
      return idx;
   endfunction

   task automatic set_msg(input int i, input logic [15:0] a, input logic [15:0] b);
      req_msg[32*i +: 32] = {a, b};
   endtask

   // One clock: sample handshakes at the negedge, then drop any requester that just fired unless it is held.
   task automatic cycle();
      logic [3:0] fire_mask;
      @(negedge clk);
      fire_mask = req_val & req_rdy;
      if (gcd_istream_val && gcd_istream_rdy) grant_log.push_back(onehot_idx(req_rdy));
      if (|(resp_val & resp_rdy)) begin
         resp_idx_log.push_back(onehot_idx(resp_val));
         resp_msg_log.push_back(int'(resp_msg));
      end
      @(posedge clk);
      #1;
      req_val = req_val & ~(fire_mask & ~hold_mask);
   endtask

   task automatic run_until_resp(input int n, input string tag);
      int k;
      k = 0;
      while (resp_msg_log.size() < n && k < 200) begin
         cycle();
         k++;
      end
      check({tag, "_resp_count"}, resp_msg_log.size(), n);
   endtask

   task automatic run_until_grant(input int n, input string tag);
      int k;
      k = 0;
      while (grant_log.size() < n && k < 200) begin
         cycle();
         k++;
      end
      check({tag, "_grant_count"}, grant_log.size(), n);
   endtask

   task automatic clear_logs();
      grant_log.delete();
      resp_idx_log.delete();
      resp_msg_log.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   function automatic int log_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -99;
   endfunction

   initial begin
      int k;
      reset     = 1'b0;
      req_val   = '0;
      req_msg   = '0;
      resp_rdy  = 4'hF;
      hold_mask = '0;
      gcd_hold  = 1'b0;
      cycle();
      cycle();
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      check("rst_req_rdy", req_rdy, 0);
      check("rst_resp_val", resp_val, 0);
      check("rst_istream_val", gcd_istream_val, 0);
      check("rst_ostream_rdy", gcd_ostream_rdy, 0);
      reset = 1'b1;
      cycle();

      // A single requester: gcd(15,5) = 5.
      clear_logs();
      set_msg(0, 16'd15, 16'd5);
      req_val[0] = 1'b1;
      run_until_grant(1, "t1");
      check("t1_busy_after_grant", busy, 1);
      check("t1_owner", owner, 0);
      run_until_resp(1, "t1");
      check("t1_grant", log_at(grant_log, 0), 0);
      check("t1_resp_idx", log_at(resp_idx_log, 0), 0);
      check("t1_resp_msg", log_at(resp_msg_log, 0), 5);
      check("t1_busy_after_resp", busy, 0);

      // All four requesters hold req_val from reset; results are 9, 6, 1 and 25.
      do_reset();
      clear_logs();
      set_msg(0, 16'd27, 16'd9);
      set_msg(1, 16'd12, 16'd18);
      set_msg(2, 16'd7, 16'd3);
      set_msg(3, 16'd100, 16'd75);
      req_val = 4'hF;
      run_until_resp(4, "t2");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_grant%0d", i), log_at(grant_log, i), i);
         check($sformatf("t2_resp_idx%0d", i), log_at(resp_idx_log, i), i);
      end
      check("t2_msg0", log_at(resp_msg_log, 0), 9);
      check("t2_msg1", log_at(resp_msg_log, 1), 6);
      check("t2_msg2", log_at(resp_msg_log, 2), 1);
      check("t2_msg3", log_at(resp_msg_log, 3), 25);

      // The pointer wraps to 0, so req0 beats req3.
      clear_logs();
      req_val = 4'b1001;
      run_until_resp(2, "wrap");
      check("wrap_grant0", log_at(grant_log, 0), 0);
      check("wrap_grant1", log_at(grant_log, 1), 3);

      // Fairness: req1 is held continuously, and req3 joins after the first grant.
      clear_logs();
      hold_mask  = 4'b1010;
      req_val[1] = 1'b1;
      run_until_grant(1, "t3a");
      req_val[3] = 1'b1;
      run_until_grant(4, "t3b");
      req_val   = '0;
      hold_mask = '0;
      run_until_resp(4, "t3");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_grant%0d", i), log_at(grant_log, i), (i % 2 == 0) ? 1 : 3);
         check($sformatf("t3_msg%0d", i), log_at(resp_msg_log, i), (i % 2 == 0) ? 6 : 25);
      end

      // Backpressure on requester 2: gcd(21,14) = 7, and req0 then asks for gcd(9,6) = 3.
      clear_logs();
      resp_rdy   = 4'b1011;
      set_msg(2, 16'd21, 16'd14);
      req_val[2] = 1'b1;
      k = 0;
      while (!resp_val[2] && k < 200) begin
         cycle();
         k++;
      end
      check("t4_resp_val_seen", resp_val[2], 1);
      set_msg(0, 16'd9, 16'd6);
      req_val[0] = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t4_stall_ostream_rdy", gcd_ostream_rdy, 0);
         check("t4_stall_resp_val", resp_val, 4'b0100);
         check("t4_stall_resp_msg", resp_msg, 7);
         check("t4_stall_req_rdy", req_rdy, 0);
      end
      check("t4_no_resp_fire", resp_msg_log.size(), 0);
      resp_rdy = 4'hF;
      cycle();
      check("t4_release_count", resp_msg_log.size(), 1);
      check("t4_release_idx", log_at(resp_idx_log, 0), 2);
      check("t4_release_msg", log_at(resp_msg_log, 0), 7);
      check("t4_idle_busy", busy, 0);
      check("t4_idle_req_rdy", req_rdy, 4'b0001);
      run_until_resp(2, "t4");
      check("t4_req0_idx", log_at(resp_idx_log, 1), 0);
      check("t4_req0_msg", log_at(resp_msg_log, 1), 3);

      // A reset in the middle of a transaction drops the owner; the next request from req3, gcd(8,4) = 4, is served.
      clear_logs();
      set_msg(1, 16'd12, 16'd18);
      req_val[1] = 1'b1;
      k = 0;
      while (!busy && k < 200) begin
         cycle();
         k++;
      end
      check("t5_owner_before", owner, 1);
      do_reset();
      check("t5_busy", busy, 0);
      check("t5_owner", owner, 0);
      check("t5_resp_val", resp_val, 0);
      clear_logs();
      set_msg(3, 16'd8, 16'd4);
      req_val[3] = 1'b1;
      run_until_resp(1, "t5");
      check("t5_grant", log_at(grant_log, 0), 3);
      check("t5_resp_idx", log_at(resp_idx_log, 0), 3);
      check("t5_resp_msg", log_at(resp_msg_log, 0), 4);

      // Retraction: req2 withdraws before the GCD unit is ready, and req0 is served afterwards.
      clear_logs();
      gcd_hold   = 1'b1;
      set_msg(2, 16'd30, 16'd12);
      req_val[2] = 1'b1;
      cycle();
      cycle();
      check("t6_req_rdy", req_rdy, 0);
      check("t6_istream_val", gcd_istream_val, 1);
      check("t6_istream_msg", gcd_istream_msg, {16'd30, 16'd12});
      req_val[2] = 1'b0;
      cycle();
      gcd_hold = 1'b0;
      cycle();
      check("t6_no_grant", grant_log.size(), 0);
      check("t6_busy", busy, 0);
      check("t6_owner_held", owner, 3);
      set_msg(0, 16'd9, 16'd6);
      req_val[0] = 1'b1;
      run_until_resp(1, "t6");
      check("t6_grant", log_at(grant_log, 0), 0);
      check("t6_resp_msg", log_at(resp_msg_log, 0), 3);
      check("t6_owner", owner, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
